// File: rtl/cache_ro_if.sv
// cache_ro_if: request/response and refill bundle for the read-only cache.
//   Requester side : valid, addr_i        -> cache
//                    data_ok, rdata1/2    <- cache
//   Refill side    : rd_req, rd_addr      <- cache
//                    ret_valid, ret_data  -> cache
//   master : the environment around the cache (requester and refill memory)
//   slave  : the cache itself
interface cache_ro_if;
   logic         valid;
   logic [31:0]  addr_i;
   logic         data_ok;
   logic [31:0]  rdata1;
   logic [31:0]  rdata2;
   logic         rd_req;
   logic [31:0]  rd_addr;
   logic         ret_valid;
   logic [127:0] ret_data;

   modport master (
      output valid, addr_i, ret_valid, ret_data,
      input  data_ok, rdata1, rdata2, rd_req, rd_addr
   );

   modport slave (
      input  valid, addr_i, ret_valid, ret_data,
      output data_ok, rdata1, rdata2, rd_req, rd_addr
   );
endinterface

// File: rtl/cache_ro.sv
// cache_ro: read-only, 2-way set-associative, blocking cache with 16-byte
// lines. Each request returns the addressed 32-bit word and the next word
// (wrapping inside the line). A miss fetches the full line over the refill
// port, installs it, and answers from the returned data.
// Ports:
//   clk  - single clock, all state on the rising edge
//   rst  - synchronous, active-high; invalidates the whole cache
//   bus  - cache_ro_if.slave: valid/addr_i request, data_ok/rdata1/rdata2
//          response, rd_req/rd_addr line read, ret_valid/ret_data refill
module cache_ro #(
   parameter int INDEX_WIDTH  = 7,
   parameter int OFFSET_WIDTH = 4,
   parameter int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
   input  logic      clk,
   input  logic      rst,
   cache_ro_if.slave bus
);

   localparam int SETS = 1 << INDEX_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOOKUP,
      S_MISS
   } state_t;

   state_t state_q, state_d;

   // Byte-within-word bits are never needed, so only [31:2] is latched.
   logic [31:2] addr_q, addr_d;

   // Per-way storage; tags and lines are qualified by the valid bits and
   // therefore carry no reset.
   logic [TAG_WIDTH-1:0] tag_q  [2][SETS];
   logic [127:0]         line_q [2][SETS];

   logic [SETS-1:0] vld0_q, vld0_d;
   logic [SETS-1:0] vld1_q, vld1_d;
   logic [SETS-1:0] lru_q,  lru_d;   // way to replace next in each set

   logic        data_ok_q, data_ok_d;
   logic        rd_req_q,  rd_req_d;
   logic [31:0] rd_addr_q, rd_addr_d;
   logic [31:0] rdata1_q,  rdata1_d;
   logic [31:0] rdata2_q,  rdata2_d;

   logic fill_we;
   logic fill_way;

   logic unused_addr_bits;
   assign unused_addr_bits = ^bus.addr_i[1:0];

   // Fields of the latched request.
   logic [TAG_WIDTH-1:0]   tag_l;
   logic [INDEX_WIDTH-1:0] idx_l;
   logic [1:0]             word_l;
   logic                   hit0;
   logic                   hit1;

   assign tag_l  = addr_q[31 -: TAG_WIDTH];
   assign idx_l  = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
   assign word_l = addr_q[3:2];

   // A matching tag only counts when the way holds a valid line.
   assign hit0 = vld0_q[idx_l] && (tag_q[0][idx_l] == tag_l);
   assign hit1 = vld1_q[idx_l] && (tag_q[1][idx_l] == tag_l);

   // Returns {next word, addressed word}; the 2-bit increment wraps 3 -> 0.
   function automatic logic [63:0] pick_words(input logic [127:0] line,
                                              input logic [1:0]   word);
      logic [1:0] next_word;
      next_word = word + 2'd1;
      return {line[{next_word, 5'd0} +: 32], line[{word, 5'd0} +: 32]};
   endfunction

   always_comb begin
      logic [127:0] hit_line;
      logic [63:0]  sel;
      logic         victim;

      state_d   = state_q;
      addr_d    = addr_q;
      vld0_d    = vld0_q;
      vld1_d    = vld1_q;
      lru_d     = lru_q;
      data_ok_d = 1'b0;
      rd_req_d  = rd_req_q;
      rd_addr_d = rd_addr_q;
      rdata1_d  = rdata1_q;
      rdata2_d  = rdata2_q;
      fill_we   = 1'b0;
      fill_way  = 1'b0;
      hit_line  = '0;
      sel       = '0;
      victim    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.valid) begin
               addr_d  = bus.addr_i[31:2];
               state_d = S_LOOKUP;
            end
         end

         S_LOOKUP: begin
            if (hit0 || hit1) begin
               hit_line     = hit1 ? line_q[1][idx_l] : line_q[0][idx_l];
               sel          = pick_words(hit_line, word_l);
               rdata1_d     = sel[31:0];
               rdata2_d     = sel[63:32];
               data_ok_d    = 1'b1;
               // Point LRU at the way that was not just used.
               lru_d[idx_l] = hit0;
               state_d      = S_IDLE;
            end else begin
               rd_req_d  = 1'b1;
               rd_addr_d = {tag_l, idx_l, {OFFSET_WIDTH{1'b0}}};
               state_d   = S_MISS;
            end
         end

         S_MISS: begin
            if (bus.ret_valid) begin
               // Fill empty ways first; only a full set consults LRU.
               if (!vld0_q[idx_l]) begin
                  victim = 1'b0;
               end else if (!vld1_q[idx_l]) begin
                  victim = 1'b1;
               end else begin
                  victim = lru_q[idx_l];
               end
               fill_we  = 1'b1;
               fill_way = victim;
               if (victim) begin
                  vld1_d[idx_l] = 1'b1;
               end else begin
                  vld0_d[idx_l] = 1'b1;
               end
               lru_d[idx_l] = ~victim;
               // Answer straight from the refill beat, not the array.
               sel       = pick_words(bus.ret_data, word_l);
               rdata1_d  = sel[31:0];
               rdata2_d  = sel[63:32];
               data_ok_d = 1'b1;
               rd_req_d  = 1'b0;
               state_d   = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         vld0_q    <= '0;
         vld1_q    <= '0;
         lru_q     <= '0;
         data_ok_q <= 1'b0;
         rd_req_q  <= 1'b0;
         rd_addr_q <= '0;
         rdata1_q  <= '0;
         rdata2_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         vld0_q    <= vld0_d;
         vld1_q    <= vld1_d;
         lru_q     <= lru_d;
         data_ok_q <= data_ok_d;
         rd_req_q  <= rd_req_d;
         rd_addr_q <= rd_addr_d;
         rdata1_q  <= rdata1_d;
         rdata2_q  <= rdata2_d;
      end
   end

   // Tag/line array write port; a refill coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (fill_we && !rst) begin
         tag_q[fill_way][idx_l]  <= tag_l;
         line_q[fill_way][idx_l] <= bus.ret_data;
      end
   end

   assign bus.data_ok = data_ok_q;
   assign bus.rd_req  = rd_req_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.rdata1  = rdata1_q;
   assign bus.rdata2  = rdata2_q;

endmodule

// File: tb/tb_cache_ro.sv
// tb_cache_ro: randomized scoreboard bench for cache_ro. The reference model
// keeps, per set, the two most recently used line addresses and the data each
// line was filled with; residency and the expected word pair follow from that.
module tb_cache_ro;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cache_ro_if bus ();

   cache_ro dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [63:0]  exp_q[$];                  // {rdata2, rdata1} expected in order
   logic [27:0]  recent[$];                 // line addresses, most recent first
   logic [127:0] cached[logic [27:0]];      // data last filled for each line

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // A line is resident if it is among the two most recent lines of its set.
   function automatic bit model_resident(input logic [27:0] la);
      int seen = 0;
      foreach (recent[i]) begin
         if (recent[i][6:0] == la[6:0]) begin
            if (recent[i] == la) return (seen < 2);
            seen++;
         end
      end
      return 1'b0;
   endfunction

   function automatic void model_touch(input logic [27:0] la);
      int seen = 0;
      for (int i = 0; i < recent.size(); i++) begin
         if (recent[i] == la) begin
            recent.delete(i);
            break;
         end
      end
      recent.push_front(la);
      for (int i = 0; i < recent.size(); i++) begin
         if (recent[i][6:0] == la[6:0]) begin
            seen++;
            if (seen > 2) begin
               recent.delete(i);
               break;
            end
         end
      end
   endfunction

   function automatic logic [63:0] words(input logic [127:0] line, input int w);
      int w2 = (w + 1) % 4;
      return {line[w2*32 +: 32], line[w*32 +: 32]};
   endfunction

   // Monitor: every data_ok must match the oldest outstanding expectation.
   always @(negedge clk) begin
      logic [63:0] e;
      if (!rst && bus.data_ok === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_data_ok: got rdata1=%h rdata2=%h, required no response",
                     bus.rdata1, bus.rdata2);
         end else begin
            e = exp_q.pop_front();
            check("rdata", {bus.rdata2, bus.rdata1}, e);
         end
      end
   end

   // Called at a negedge; returns at the negedge where data_ok is visible.
   task automatic issue(input logic [31:0] a, input logic [127:0] fill,
                        input int wait_cyc, input bit noise);
      logic [27:0]  la   = a[31:4];
      bit           hit  = model_resident(la);
      logic [127:0] line;
      line = hit ? cached[la] : fill;
      exp_q.push_back(words(line, int'(a[3:2])));
      if (!hit) cached[la] = fill;
      model_touch(la);

      bus.valid  = 1'b1;
      bus.addr_i = a;
      @(negedge clk);
      bus.valid  = 1'b0;
      bus.addr_i = $urandom;
      @(negedge clk);
      check("hit_data_ok", {127'd0, bus.data_ok}, {127'd0, hit});
      check("rd_req_rise", {127'd0, bus.rd_req}, {127'd0, !hit});
      if (!hit) begin
         check("rd_addr", {96'd0, bus.rd_addr}, {96'd0, a[31:4], 4'h0});
         for (int k = 0; k < wait_cyc; k++) begin
            // A request during MISS must be ignored.
            bus.valid  = noise && (k == 0);
            bus.addr_i = $urandom;
            @(negedge clk);
         end
         bus.valid = 1'b0;
         check("rd_req_hold", {127'd0, bus.rd_req}, 128'd1);
         check("rd_addr_hold", {96'd0, bus.rd_addr}, {96'd0, a[31:4], 4'h0});
         bus.ret_valid = 1'b1;
         bus.ret_data  = fill;
         @(negedge clk);
         bus.ret_valid = 1'b0;
         bus.ret_data  = {4{$urandom}};
         check("miss_data_ok", {127'd0, bus.data_ok}, 128'd1);
         check("rd_req_drop", {127'd0, bus.rd_req}, 128'd0);
      end
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.valid     = 1'b0;
      bus.ret_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      recent.delete();
      cached.delete();
      exp_q.delete();
      check("rst_data_ok", {127'd0, bus.data_ok}, 128'd0);
      check("rst_rd_req", {127'd0, bus.rd_req}, 128'd0);
      check("rst_rd_addr", {96'd0, bus.rd_addr}, 128'd0);
      check("rst_rdata1", {96'd0, bus.rdata1}, 128'd0);
      check("rst_rdata2", {96'd0, bus.rdata2}, 128'd0);
   endtask

   // ret_valid while idle must produce nothing.
   task automatic spurious_ret();
      bus.ret_valid = 1'b1;
      bus.ret_data  = {4{$urandom}};
      @(negedge clk);
      bus.ret_valid = 1'b0;
      @(negedge clk);
      check("spurious_ret", {127'd0, bus.data_ok}, 128'd0);
   endtask

   initial begin
      logic [31:0]  a;
      logic [20:0]  tags [4];
      logic [6:0]   idxs [4];
      tags = '{21'h00001, 21'h00002, 21'h1FFFF, 21'h0ABCD};
      idxs = '{7'd0, 7'd1, 7'd64, 7'd127};

      bus.valid     = 1'b0;
      bus.addr_i    = '0;
      bus.ret_valid = 1'b0;
      bus.ret_data  = '0;
      @(negedge clk);
      do_reset();

      // Cold miss, then hits including the wrap case.
      issue(32'hDEBAD000, 128'h34567891_02345678_91023456_78910234, 7, 1'b0);
      issue(32'hDEBAD004, '0, 0, 1'b0);
      issue(32'hDEBAD00C, '0, 0, 1'b0);
      @(negedge clk);
      spurious_ret();

      // Address 0 after reset must miss although stored tags may be zero.
      do_reset();
      issue(32'h00000000, {4{$urandom}}, 2, 1'b0);

      // Replacement in set 0: C must evict B, not A.
      do_reset();
      issue(32'h00001000, {4{$urandom}}, 1, 1'b0);
      issue(32'h00002004, {4{$urandom}}, 0, 1'b1);
      issue(32'h00001008, '0, 0, 1'b0);
      issue(32'h0000300C, {4{$urandom}}, 3, 1'b0);
      issue(32'h00001000, '0, 0, 1'b0);
      issue(32'h00002000, {4{$urandom}}, 1, 1'b0);

      // Reset while a miss is outstanding.
      do_reset();
      bus.valid  = 1'b1;
      bus.addr_i = 32'h12345670;
      @(negedge clk);
      bus.valid = 1'b0;
      @(negedge clk);
      check("abort_rd_req_before", {127'd0, bus.rd_req}, 128'd1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_rd_req_after", {127'd0, bus.rd_req}, 128'd0);
      check("abort_data_ok", {127'd0, bus.data_ok}, 128'd0);
      rst = 1'b0;
      recent.delete();
      cached.delete();
      exp_q.delete();
      spurious_ret();
      issue(32'h12345670, {4{$urandom}}, 2, 1'b0);

      // Randomized traffic over a small pool so sets fill and evict.
      for (int n = 0; n < 250; n++) begin
         a = {tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 3)],
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         issue(a, {4{$urandom}}, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 9) == 0) begin
            @(negedge clk);
            spurious_ret();
         end
      end

      repeat (3) @(negedge clk);
      check("responses_drained", 128'(exp_q.size()), 128'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Backstop so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end
endmodule

// File: doc/cache_ro.md
Name: cache_ro

Overview:
- Read-only, 2-way set-associative, blocking instruction/data cache between a requester (single-cycle `valid` pulse plus address) and a line-refill memory port.
- Each request returns two consecutive 32-bit words from one 16-byte line: the addressed word and the next word, wrapping within the line.
- A miss issues a line read, installs the returned 128-bit line, then answers the request.

Parameters:
- INDEX_WIDTH, 7, set index bits (128 sets).
- OFFSET_WIDTH, 4, byte offset bits (16-byte line); fixed at 4.
- TAG_WIDTH, 32-INDEX_WIDTH-OFFSET_WIDTH (21), tag bits.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- valid  in  1  request strobe, one cycle; sampled only in IDLE.
- addr_i  in  32  byte address. Tag = addr_i[31:11], index = addr_i[10:4], word = addr_i[3:2], addr_i[1:0] ignored.
- data_ok  out  1  one-cycle pulse; rdata1/rdata2 valid this cycle.
- rdata1  out  32  word at addr[3:2].
- rdata2  out  32  word at (addr[3:2]+1) mod 4.
- rd_req  out  1  line read request, level.
- rd_addr  out  32  line-aligned address {tag,index,4'b0}.
- ret_valid  in  1  refill data valid, one cycle.
- ret_data  in  128  refill line. Word0 = [31:0], word1 = [63:32], word2 = [95:64], word3 = [127:96].

Behaviour:
- Storage per set and way: valid bit, tag, 128-bit line. One LRU bit per set (names the way to replace next).
- Reset values:
  - all valid bits 0, all LRU 0, state IDLE;
  - data_ok = 0, rd_req = 0, rd_addr = 0, rdata1 = 0, rdata2 = 0.
  - Line and tag contents need no reset.
- FSM states: IDLE, LOOKUP, MISS.
- IDLE: on valid=1, latch addr_i and go to LOOKUP. Otherwise stay.
- LOOKUP:
  - Compare the latched tag against both ways of the latched index; a way hits only if its valid bit is 1. A matching tag with valid=0 is a miss.
  - Hit: register the selected words into rdata1/rdata2 and assert data_ok for the next cycle only. Set LRU to the other way. Go to IDLE.
  - Miss: rd_req=1, rd_addr={tag,index,4'h0}, go to MISS.
- MISS:
  - Hold rd_req=1 and rd_addr stable until a cycle with ret_valid=1.
  - On that cycle, choose the victim: way0 if invalid, else way1 if invalid, else the LRU way.
  - Write ret_data and the tag into the victim, set its valid bit, set LRU to the other way.
  - Drop rd_req the next cycle. Register the words selected from ret_data (not from the array) into rdata1/rdata2, pulse data_ok for the next cycle, go to IDLE.
- Latency: hit has data_ok 2 cycles after the valid edge. Miss has data_ok 1 cycle after the ret_valid edge. rd_req rises 2 cycles after the valid edge.
- valid outside IDLE is ignored (no queuing). The data_ok cycle is already IDLE, so a new request may be accepted in that cycle.
- ret_valid outside MISS is ignored.
- rdata1/rdata2 hold their last values between data_ok pulses.
- rst asserted in any state, including mid-MISS, aborts the transaction. Outputs return to reset values and the whole cache is invalidated.
- Word wrap: word 3 gives rdata1=word3, rdata2=word0.

Test Plan:
- Cold miss: after reset, valid with addr_i=0xDEBAD000 -> rd_req=1 with rd_addr=0xDEBAD000. Drive ret_valid 7 cycles later with ret_data=0x34567891_02345678_91023456_78910234 -> data_ok pulse, rdata1=0x78910234, rdata2=0x91023456.
- Hit: then addr_i=0xDEBAD004 -> no rd_req; data_ok 2 cycles after valid; rdata1=0x91023456, rdata2=0x02345678.
- Wrap: addr_i=0xDEBAD00C -> hit, rdata1=0x34567891, rdata2=0x78910234.
- Invalid-tag miss: after reset, addr_i=0x00000000 -> miss (rd_req, rd_addr=0) even though stored tag bits may equal 0.
- Replacement: fill index 0 with tags A and B, re-read A, then miss on tag C.
  - C must evict B; A still hits, B misses.
- Reset mid-miss: assert rst while rd_req=1 -> rd_req=0 next cycle. A late ret_valid produces no data_ok. The same address misses again afterwards.
